led_pattern_gen: RTL and testbench

Generates the 16-bit LED bitmap animation that feeds the board's LED serial wrapper (`bitmap` input of the LED shift-out stage). It provides a free-running prescaler, four animation modes, a synchronous seed load, and a wrap pulse at the end of each animation period. Its `bitmap` output is registered and changes at most once per prescaler tick, so the downstream serial driver always samples a stable value.

---
 rtl/led_pattern_gen_if.sv | 13 +
 rtl/led_pattern_gen.sv | 139 +++++++++++++
 tb/tb_led_pattern_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between the LED animation source and its consumer.
// The master side drives mode/load/seed/hold and observes bitmap/wrap.
interface led_pattern_gen_if;
    logic [1:0]  mode;
    logic        load;
    logic [15:0] seed;
    logic        hold;
    logic [15:0] bitmap;
    logic        wrap;

    modport master (output mode, load, seed, hold, input bitmap, wrap);
    modport slave  (input mode, load, seed, hold, output bitmap, wrap);
endinterface

// File: rtl/led_pattern_gen.sv
// LED bitmap animation generator feeding the LED serial shift-out stage.
// A free-running prescaler produces one animation step every 2^DIV_BITS
// clocks; the step applied depends on the registered mode (rotate, bounce,
// fill/drain, or mode 0). Mode 0 is a Galois LFSR when LED_PATTERN_LFSR_EN
// is defined and a constant hold of the bitmap otherwise.
module led_pattern_gen #(
    parameter int DIV_BITS = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    led_pattern_gen_if.slave        bus
);

    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic {PHASE_FILL, PHASE_DRAIN} phase_t;

    logic [DIV_BITS-1:0] prescaler;
    logic                tick;
    logic [1:0]          mode_q;
    logic [15:0]         bitmap_q;
    logic                wrap_q;
    dir_t                dir_q;
    phase_t              phase_q;

    logic [15:0]         step_bitmap;
    dir_t                step_dir;
    phase_t              step_phase;
    logic                step_wrap;

    assign tick       = (prescaler == '1) && !bus.hold;
    assign bus.bitmap = bitmap_q;
    assign bus.wrap   = wrap_q;

    // Next animation frame for the current registered mode, used only on a tick.
    always_comb begin
        step_bitmap = bitmap_q;
        step_dir    = dir_q;
        step_phase  = phase_q;
        step_wrap   = 1'b0;
        case (mode_q)
            2'd0: begin
`ifdef LED_PATTERN_LFSR_EN
                if (bitmap_q == 16'h0000) begin
                    step_bitmap = 16'h0001;
                end else begin
                    step_bitmap = (bitmap_q >> 1) ^ (bitmap_q[0] ? 16'hB400 : 16'h0000);
                end
                step_wrap = (step_bitmap == 16'h0001);
`else
                step_bitmap = bitmap_q;
`endif
            end
            2'd1: begin
                step_bitmap = {bitmap_q[14:0], bitmap_q[15]};
                step_wrap   = bitmap_q[15];
            end
            2'd2: begin
                if (bitmap_q == 16'h0000) begin
                    step_bitmap = 16'h0001;
                    step_dir    = DIR_LEFT;
                end else if (dir_q == DIR_LEFT) begin
                    if (bitmap_q[15]) begin
                        step_dir    = DIR_RIGHT;
                        step_bitmap = bitmap_q >> 1;
                    end else begin
                        step_bitmap = bitmap_q << 1;
                    end
                end else begin
                    if (bitmap_q[0]) begin
                        step_dir    = DIR_LEFT;
                        step_bitmap = bitmap_q << 1;
                        step_wrap   = 1'b1;
                    end else begin
                        step_bitmap = bitmap_q >> 1;
                    end
                end
            end
            default: begin
                if (phase_q == PHASE_FILL) begin
                    if (bitmap_q == 16'hFFFF) begin
                        step_phase  = PHASE_DRAIN;
                        step_bitmap = 16'hFFFE;
                    end else begin
                        step_bitmap = {bitmap_q[14:0], 1'b1};
                    end
                end else begin
                    if (bitmap_q == 16'h0000) begin
                        step_phase  = PHASE_FILL;
                        step_bitmap = 16'h0001;
                        step_wrap   = 1'b1;
                    end else begin
                        step_bitmap = bitmap_q << 1;
                    end
                end
            end
        endcase
    end

    // State update with load over mode change over tick; wrap is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            mode_q    <= 2'd0;
            bitmap_q  <= 16'h0001;
            wrap_q    <= 1'b0;
            dir_q     <= DIR_LEFT;
            phase_q   <= PHASE_FILL;
        end else begin
            wrap_q <= 1'b0;
            if (bus.load) begin
                bitmap_q  <= bus.seed;
                prescaler <= '0;
                dir_q     <= DIR_LEFT;
                phase_q   <= PHASE_FILL;
            end else if (bus.mode != mode_q) begin
                mode_q    <= bus.mode;
                prescaler <= '0;
                dir_q     <= DIR_LEFT;
                phase_q   <= PHASE_FILL;
                case (bus.mode)
                    2'd1, 2'd2: bitmap_q <= 16'h0001;
                    2'd3:       bitmap_q <= 16'h0000;
                    default:    bitmap_q <= bitmap_q;
                endcase
            end else begin
                if (!bus.hold) begin
                    prescaler <= prescaler + 1'b1;
                end
                if (tick) begin
                    bitmap_q <= step_bitmap;
                    dir_q    <= step_dir;
                    phase_q  <= step_phase;
                    wrap_q   <= step_wrap;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen with DIV_BITS=2 (one tick every 4 clocks).
// Vector records hold inputs plus expected bitmap/wrap after their last edge;
// intermediate edges of each record expect the bitmap unchanged and wrap low.
module tb_led_pattern_gen;

    typedef struct {
        logic [1:0]  mode;
        logic        load;
        logic [15:0] seed;
        logic        hold;
        int          edges;
        logic [15:0] exp_bitmap;
        logic        exp_wrap;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] bitmap;
        logic        wrap;
        string       name;
    } exp_t;

    logic clk;
    logic rst;

    led_pattern_gen_if bus ();

    led_pattern_gen #(.DIV_BITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    vec_t        vecs[$];
    exp_t        exp_q[$];
    logic [15:0] last_bitmap;
    int          n_checks;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic [1:0] mode, input logic load, input logic [15:0] seed,
                           input logic hold, input int edges, input logic [15:0] exp_bitmap,
                           input logic exp_wrap, input string name);
        vec_t v;
        v.mode       = mode;
        v.load       = load;
        v.seed       = seed;
        v.hold       = hold;
        v.edges      = edges;
        v.exp_bitmap = exp_bitmap;
        v.exp_wrap   = exp_wrap;
        v.name       = name;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [15:0] bitmap, input logic wrap, input string name);
        exp_t e;
        e.bitmap = bitmap;
        e.wrap   = wrap;
        e.name   = name;
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_empty: bitmap=%h wrap=%b, no expectation queued",
                     bus.bitmap, bus.wrap);
        end else begin
            e = exp_q.pop_front();
            if (bus.bitmap !== e.bitmap || bus.wrap !== e.wrap) begin
                n_fail++;
                $display("[TB] FAIL %s: got bitmap=%h wrap=%b, expected bitmap=%h wrap=%b",
                         e.name, bus.bitmap, bus.wrap, e.bitmap, e.wrap);
            end
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.mode = v.mode;
        bus.hold = v.hold;
        bus.seed = v.seed;
        bus.load = 1'b0;
        for (int i = 0; i < v.edges; i++) begin
            if (i == v.edges - 1) begin
                bus.load = v.load;
                push_exp(v.exp_bitmap, v.exp_wrap, v.name);
            end else begin
                push_exp(last_bitmap, 1'b0, {v.name, "_quiet"});
            end
            @(posedge clk);
            #1;
            bus.load = 1'b0;
            check_output();
        end
        last_bitmap = v.exp_bitmap;
    endtask

    initial begin
        logic [15:0] one;
        logic [15:0] ones;
        logic [15:0] e;
        vec_t        v;
        one      = 16'h0001;
        ones     = 16'hFFFF;
        n_checks = 0;
        n_fail   = 0;

        // Rotate: 16 ticks around the ring, wrap only on 8000 -> 0001.
        add_vec(2'd1, 1'b0, 16'h0, 1'b0, 1, 16'h0001, 1'b0, "rot_init");
        for (int t = 1; t <= 16; t++) begin
            e = one << (t % 16);
            add_vec(2'd1, 1'b0, 16'h0, 1'b0, 4, e, (t == 16), $sformatf("rot_tick%0d", t));
        end

        // Bounce: up to 8000 at tick 15, back to 0001 at tick 30, 0002 + wrap at 31.
        add_vec(2'd2, 1'b0, 16'h0, 1'b0, 1, 16'h0001, 1'b0, "bnc_init");
        for (int t = 1; t <= 31; t++) begin
            if (t <= 15)      e = one << t;
            else if (t <= 30) e = one << (30 - t);
            else              e = 16'h0002;
            add_vec(2'd2, 1'b0, 16'h0, 1'b0, 4, e, (t == 31), $sformatf("bnc_tick%0d", t));
        end

        // Fill/drain: FFFF at tick 16, FFFE at 17, 0000 at 32, 0001 + wrap at 33.
        add_vec(2'd3, 1'b0, 16'h0, 1'b0, 1, 16'h0000, 1'b0, "fd_init");
        for (int t = 1; t <= 33; t++) begin
            if (t <= 16)      e = ones >> (16 - t);
            else if (t <= 32) e = ones << (t - 16);
            else              e = 16'h0001;
            add_vec(2'd3, 1'b0, 16'h0, 1'b0, 4, e, (t == 33), $sformatf("fd_tick%0d", t));
        end

        // Load coincident with a tick edge wins; next tick rotates A5A5 with wrap.
        add_vec(2'd1, 1'b0, 16'h0,    1'b0, 1, 16'h0001, 1'b0, "ld_mode");
        add_vec(2'd1, 1'b0, 16'h0,    1'b0, 4, 16'h0002, 1'b0, "ld_pre_tick");
        add_vec(2'd1, 1'b1, 16'hA5A5, 1'b0, 4, 16'hA5A5, 1'b0, "ld_on_tick");
        add_vec(2'd1, 1'b0, 16'h0,    1'b0, 4, 16'h4B4B, 1'b1, "ld_next_tick");

        // Hold freezes stepping but not mode re-initialisation.
        add_vec(2'd1, 1'b0, 16'h0, 1'b1, 100, 16'h4B4B, 1'b0, "hold_100");
        add_vec(2'd3, 1'b0, 16'h0, 1'b1, 1,   16'h0000, 1'b0, "hold_mode_chg");
        add_vec(2'd3, 1'b0, 16'h0, 1'b1, 8,   16'h0000, 1'b0, "hold_frozen");
        add_vec(2'd3, 1'b0, 16'h0, 1'b0, 4,   16'h0001, 1'b0, "hold_release");

        // Mode 0 keeps the bitmap on entry, then LFSR or constant hold.
        add_vec(2'd0, 1'b0, 16'h0, 1'b0, 1, 16'h0001, 1'b0, "m0_init");
`ifdef LED_PATTERN_LFSR_EN
        add_vec(2'd0, 1'b0, 16'h0, 1'b0, 4, 16'hB400, 1'b0, "lfsr_tick1");
        add_vec(2'd0, 1'b0, 16'h0, 1'b0, 4, 16'h5A00, 1'b0, "lfsr_tick2");
        add_vec(2'd0, 1'b0, 16'h0, 1'b0, 4, 16'h2D00, 1'b0, "lfsr_tick3");
`else
        add_vec(2'd0, 1'b0, 16'h0, 1'b0, 4, 16'h0001, 1'b0, "m0_tick1");
        add_vec(2'd0, 1'b0, 16'h0, 1'b0, 4, 16'h0001, 1'b0, "m0_tick2");
        add_vec(2'd0, 1'b0, 16'h0, 1'b0, 4, 16'h0001, 1'b0, "m0_tick3");
`endif

        // Setup ahead of the mid-operation async reset.
        add_vec(2'd1, 1'b0, 16'h0, 1'b0, 1, 16'h0001, 1'b0, "pre_rst_mode");
        add_vec(2'd1, 1'b0, 16'h0, 1'b0, 4, 16'h0002, 1'b0, "pre_rst_tick1");
        add_vec(2'd1, 1'b0, 16'h0, 1'b0, 4, 16'h0004, 1'b0, "pre_rst_tick2");

        $display("[TB] Starting led_pattern_gen test, %0d vectors", vecs.size());

        bus.mode = 2'd0;
        bus.load = 1'b0;
        bus.seed = 16'h0000;
        bus.hold = 1'b0;
        rst      = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        push_exp(16'h0001, 1'b0, "reset_state");
        check_output();
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_bitmap = 16'h0001;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
        end

        // Async reset between edges must clear the bitmap without a clock.
        @(negedge clk);
        rst = 1'b1;
        #1;
        push_exp(16'h0001, 1'b0, "async_rst");
        check_output();
        #1;
        rst = 1'b0;
        last_bitmap = 16'h0001;

        // After reset mode_q is 0, so mode 1 is a fresh change and ticks restart.
        v.mode = 2'd1; v.load = 1'b0; v.seed = 16'h0; v.hold = 1'b0;
        v.edges = 1; v.exp_bitmap = 16'h0001; v.exp_wrap = 1'b0; v.name = "post_rst_mode";
        apply_stimulus(v);
        v.edges = 4; v.exp_bitmap = 16'h0002; v.name = "post_rst_tick1";
        apply_stimulus(v);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
